cache_core_rsp_sched: RTL and testbench

- Round-robin scheduler and coalescer for cache bank responses heading back to the core.
- Each cycle it picks one leader bank in rotating order. It then gathers every other bank response carrying the same request tag ID into one multi-lane core response.
- That response is registered into a single-entry output stage with ready/valid flow control.
- Sits between the per-bank core response ports and the cache's core response bus. Replaces fixed lowest-index priority with fair arbitration.

---
 rtl/cache_core_rsp_sched_if.sv | 27 ++
 rtl/cache_core_rsp_sched.sv | 109 ++++++++++
 tb/tb_cache_core_rsp_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cache_core_rsp_sched_if.sv
// cache_core_rsp_sched_if: bank-response inputs and merged core-response output of the scheduler.
interface cache_core_rsp_sched_if #(
    parameter int NUM_BANKS      = 4,
    parameter int NUM_REQS       = 4,
    parameter int WORD_SIZE      = 4,
    parameter int CORE_TAG_WIDTH = 8
);
    localparam int WORD_W    = 8 * WORD_SIZE;
    localparam int REQS_BITS = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1;
    logic [NUM_BANKS-1:0]                per_bank_rsp_valid;
    logic [NUM_BANKS*CORE_TAG_WIDTH-1:0] per_bank_rsp_tag;
    logic [NUM_BANKS*REQS_BITS-1:0]      per_bank_rsp_tid;
    logic [NUM_BANKS*WORD_W-1:0]         per_bank_rsp_data;
    logic [NUM_BANKS-1:0]                per_bank_rsp_ready;
    logic [NUM_REQS-1:0]                 core_rsp_valid;
    logic [CORE_TAG_WIDTH-1:0]           core_rsp_tag;
    logic [NUM_REQS*WORD_W-1:0]          core_rsp_data;
    logic                                core_rsp_ready;
    modport slave (
        input  per_bank_rsp_valid, per_bank_rsp_tag, per_bank_rsp_tid, per_bank_rsp_data, core_rsp_ready,
        output per_bank_rsp_ready, core_rsp_valid, core_rsp_tag, core_rsp_data
    );
    modport master (
        output per_bank_rsp_valid, per_bank_rsp_tag, per_bank_rsp_tid, per_bank_rsp_data, core_rsp_ready,
        input  per_bank_rsp_ready, core_rsp_valid, core_rsp_tag, core_rsp_data
    );
endinterface

// File: rtl/cache_core_rsp_sched.sv
// cache_core_rsp_sched: round-robin leader pick, same-tag-ID lane merge, single-entry output stage.
// Defining CORE_RSP_SCHED_PERF_EN adds stall/conflict/merge performance counters.
module cache_core_rsp_sched #(
    parameter int NUM_BANKS        = 4,
    parameter int NUM_REQS         = 4,
    parameter int WORD_SIZE        = 4,
    parameter int CORE_TAG_WIDTH   = 8,
    parameter int CORE_TAG_ID_BITS = 4
) (
    input logic clk,
    input logic reset,
    cache_core_rsp_sched_if.slave bus
`ifdef CORE_RSP_SCHED_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_conflict_cycles,
    output logic [31:0] perf_merged_rsps
`endif
);
    localparam int WORD_W    = 8 * WORD_SIZE;
    localparam int REQS_BITS = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1;
    localparam int BANK_BITS = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;

    function automatic int rot(input int base, input int k);
        return (base + k) % NUM_BANKS;
    endfunction

    logic [CORE_TAG_WIDTH-1:0]   tag    [NUM_BANKS];
    logic [CORE_TAG_ID_BITS-1:0] tag_id [NUM_BANKS];
    logic [REQS_BITS-1:0]        tid    [NUM_BANKS];
    logic [WORD_W-1:0]           data   [NUM_BANKS];

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_unpack
        assign tag[g]    = bus.per_bank_rsp_tag[g*CORE_TAG_WIDTH +: CORE_TAG_WIDTH];
        assign tag_id[g] = bus.per_bank_rsp_tag[g*CORE_TAG_WIDTH +: CORE_TAG_ID_BITS];
        assign tid[g]    = bus.per_bank_rsp_tid[g*REQS_BITS +: REQS_BITS];
        assign data[g]   = bus.per_bank_rsp_data[g*WORD_W +: WORD_W];
    end

    logic [BANK_BITS-1:0]       rr_ptr, leader;
    logic                       has_leader, conflict, out_valid, can_accept, accept;
    logic [NUM_BANKS-1:0]       joined;
    logic [NUM_REQS-1:0]        lane_mask;
    logic [NUM_REQS*WORD_W-1:0] lane_data;

    always_comb begin
        has_leader = 1'b0;
        leader     = '0;
        for (int k = 0; k < NUM_BANKS; k++)
            if (!has_leader && bus.per_bank_rsp_valid[rot(int'(rr_ptr), k)]) begin
                has_leader = 1'b1;
                leader     = BANK_BITS'(rot(int'(rr_ptr), k));
            end
    end

    // The leader is visited first, so it always claims its own lane.
    always_comb begin
        joined    = '0;
        lane_mask = '0;
        lane_data = '0;
        conflict  = 1'b0;
        for (int k = 0; k < NUM_BANKS; k++)
            if (has_leader && bus.per_bank_rsp_valid[rot(int'(leader), k)]
                && tag_id[rot(int'(leader), k)] == tag_id[leader]) begin
                if (lane_mask[tid[rot(int'(leader), k)]])
                    conflict = 1'b1;
                else begin
                    joined[rot(int'(leader), k)]       = 1'b1;
                    lane_mask[tid[rot(int'(leader), k)]] = 1'b1;
                    lane_data[int'(tid[rot(int'(leader), k)])*WORD_W +: WORD_W] = data[rot(int'(leader), k)];
                end
            end
    end

    assign out_valid              = |bus.core_rsp_valid;
    assign can_accept             = !out_valid || bus.core_rsp_ready;
    assign accept                 = has_leader && can_accept;
    assign bus.per_bank_rsp_ready = (accept && reset) ? joined : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr             <= '0;
            bus.core_rsp_valid <= '0;
            bus.core_rsp_tag   <= '0;
            bus.core_rsp_data  <= '0;
        end else if (accept) begin
            rr_ptr             <= (leader == BANK_BITS'(NUM_BANKS - 1)) ? '0 : leader + 1'b1;
            bus.core_rsp_valid <= lane_mask;
            bus.core_rsp_tag   <= tag[leader];
            bus.core_rsp_data  <= lane_data;
        end else if (bus.core_rsp_ready) begin
            bus.core_rsp_valid <= '0;
        end
    end

`ifdef CORE_RSP_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles    <= '0;
            perf_conflict_cycles <= '0;
            perf_merged_rsps     <= '0;
        end else begin
            if (out_valid && !bus.core_rsp_ready) perf_stall_cycles <= perf_stall_cycles + 1;
            if (accept && conflict) perf_conflict_cycles <= perf_conflict_cycles + 1;
            if (accept && !$onehot(lane_mask)) perf_merged_rsps <= perf_merged_rsps + 1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_core_rsp_sched.sv
// tb_cache_core_rsp_sched: directed vectors with hand-computed expectations for the response scheduler.
module tb_cache_core_rsp_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vecs = 0;
    int errs = 0;

    logic       bv   [4];
    logic [7:0] btag [4];
    logic [1:0] btid [4];
    logic [31:0] bdat[4];

    cache_core_rsp_sched_if bus();

`ifdef CORE_RSP_SCHED_PERF_EN
    logic [31:0] perf_stall_cycles, perf_conflict_cycles, perf_merged_rsps;
`endif

    cache_core_rsp_sched dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef CORE_RSP_SCHED_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_conflict_cycles(perf_conflict_cycles),
        .perf_merged_rsps(perf_merged_rsps)
`endif
    );

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign bus.per_bank_rsp_valid[g]          = bv[g];
        assign bus.per_bank_rsp_tag[g*8 +: 8]     = btag[g];
        assign bus.per_bank_rsp_tid[g*2 +: 2]     = btid[g];
        assign bus.per_bank_rsp_data[g*32 +: 32]  = bdat[g];
    end

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_bank(input int i, input logic v, input logic [7:0] t, input logic [1:0] d, input logic [31:0] w);
        bv[i] = v; btag[i] = t; btid[i] = d; bdat[i] = w;
    endtask

    task automatic exp_ready(input string name, input logic [3:0] exp);
        #1;
        chk(name, 128'(bus.per_bank_rsp_ready), 128'(exp));
    endtask

    // Advances one edge; banks that were granted drop valid unless keep is set.
    task automatic tick(input bit keep);
        logic [3:0] r;
        r = bus.per_bank_rsp_ready;
        @(posedge clk);
        #1;
        if (!keep)
            for (int i = 0; i < 4; i++) if (r[i]) bv[i] = 1'b0;
    endtask

    task automatic exp_out(input string name, input logic [3:0] v, input logic [7:0] t, input logic [127:0] d);
        chk({name, "_valid"}, 128'(bus.core_rsp_valid), 128'(v));
        chk({name, "_tag"}, 128'(bus.core_rsp_tag), 128'(t));
        chk({name, "_data"}, bus.core_rsp_data, d);
    endtask

    task automatic load_distinct();
        for (int i = 0; i < 4; i++)
            set_bank(i, 1'b1, 8'(8'h10 * (i + 1) + i), 2'(i), 32'hD000_0000 + 32'(i));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) set_bank(i, 1'b0, 8'h0, 2'h0, 32'h0);
        bus.core_rsp_ready = 1'b1;
        #1 reset = 1'b0;
        load_distinct();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 128'(bus.per_bank_rsp_ready), 128'h0);
        exp_out("rst", 4'h0, 8'h00, 128'h0);
        reset = 1'b1;
        exp_ready("rel_ready", 4'b0001);

        // Continuous valid, distinct tag IDs: leaders 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            if (k > 0) exp_ready("rr_ready", 4'(1 << (k % 4)));
            tick(1'b1);
            exp_out("rr", 4'(1 << (k % 4)), btag[k % 4], 128'(bdat[k % 4]) << (32 * (k % 4)));
        end
        for (int i = 0; i < 4; i++) bv[i] = 1'b0;
        tick(1'b0);
        chk("rr_drain", 128'(bus.core_rsp_valid), 128'h0);

        // Steer rr_ptr back to 0 via bank 3.
        set_bank(3, 1'b1, 8'h07, 2'd3, 32'h7777_0007);
        exp_ready("steer_ready", 4'b1000);
        tick(1'b0);
        exp_out("steer", 4'b1000, 8'h07, {32'h7777_0007, 96'h0});

        set_bank(0, 1'b1, 8'h13, 2'd1, 32'h1111_AAAA);
        set_bank(2, 1'b1, 8'h23, 2'd2, 32'h2222_BBBB);
        set_bank(1, 1'b1, 8'h05, 2'd0, 32'h3333_CCCC);
        exp_ready("merge_ready", 4'b0101);
        tick(1'b0);
        exp_out("merge", 4'b0110, 8'h13, {32'h0, 32'h2222_BBBB, 32'h1111_AAAA, 32'h0});
        exp_ready("merge2_ready", 4'b0010);
        tick(1'b0);
        exp_out("merge2", 4'b0001, 8'h05, {96'h0, 32'h3333_CCCC});

        bus.core_rsp_ready = 1'b0;
        set_bank(2, 1'b1, 8'h0A, 2'd3, 32'hEEEE_0001);
        for (int k = 0; k < 3; k++) begin
            exp_ready("stall_ready", 4'b0000);
            tick(1'b0);
            exp_out("stall", 4'b0001, 8'h05, {96'h0, 32'h3333_CCCC});
        end
        bus.core_rsp_ready = 1'b1;
        exp_ready("unstall_ready", 4'b0100);
        tick(1'b0);
        exp_out("unstall", 4'b1000, 8'h0A, {32'hEEEE_0001, 96'h0});
`ifdef CORE_RSP_SCHED_PERF_EN
        chk("perf_stall", 128'(perf_stall_cycles), 128'd3);
`endif
        tick(1'b0);
        chk("bp_drain", 128'(bus.core_rsp_valid), 128'h0);

        set_bank(0, 1'b1, 8'h03, 2'd2, 32'hF0F0_0000);
        set_bank(1, 1'b1, 8'h13, 2'd2, 32'h0606_0606);
        exp_ready("conf_ready", 4'b0001);
        tick(1'b0);
        exp_out("conf", 4'b0100, 8'h03, {32'h0, 32'hF0F0_0000, 64'h0});
        exp_ready("conf2_ready", 4'b0010);
        tick(1'b0);
        exp_out("conf2", 4'b0100, 8'h13, {32'h0, 32'h0606_0606, 64'h0});
`ifdef CORE_RSP_SCHED_PERF_EN
        chk("perf_conflict", 128'(perf_conflict_cycles), 128'd1);
        chk("perf_merged", 128'(perf_merged_rsps), 128'd1);
`endif
        tick(1'b0);
        chk("conf_drain", 128'(bus.core_rsp_valid), 128'h0);

        // Load one response (rr_ptr -> 3), stall it, then reset asynchronously.
        bus.core_rsp_ready = 1'b0;
        set_bank(2, 1'b1, 8'h02, 2'd1, 32'h4848_4848);
        exp_ready("pre_rst_ready", 4'b0100);
        tick(1'b0);
        exp_out("pre_rst", 4'b0010, 8'h02, {64'h0, 32'h4848_4848, 32'h0});
        #2 reset = 1'b0;
        #1;
        exp_out("async_rst", 4'b0000, 8'h00, 128'h0);
        chk("async_rst_ready", 128'(bus.per_bank_rsp_ready), 128'h0);
`ifdef CORE_RSP_SCHED_PERF_EN
        chk("perf_rst", 128'(perf_stall_cycles), 128'd0);
`endif
        load_distinct();
        reset = 1'b1;
        exp_ready("post_rst_ready", 4'b0001);
        tick(1'b0);
        exp_out("post_rst", 4'b0001, 8'h10, {96'h0, 32'hD000_0000});

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
